// File: rtl/python_spi_master.sv
// SPI master for the PYTHON sensor: 26-bit frames {addr[8:0], we, data[15:0]} sent MSB first.
// Define PYTHON_SPI_MASTER_READBACK_EN to return the MISO-sampled word on reads; otherwise reads return 16'h0000.
module python_spi_master #(
    parameter int CLK_DIV = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [8:0]  python_spi_addr,
    input  logic        python_spi_we,
    input  logic [15:0] python_spi_wdata,
    input  logic        python_spi_valid,
    output logic        python_spi_ready,
    output logic [15:0] python_spi_rdata,
    output logic        python_spi_rvalid,
    output logic        python_ss_n,
    output logic        python_sck,
    output logic        python_mosi,
    input  logic        python_miso
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    state_t      state;
    logic [7:0]  cnt;
    logic [4:0]  bit_idx;
    logic        is_read;
    logic [25:0] frame_q;
    logic [15:0] rx_word;

    logic cnt_end;
    logic accept;
    logic sck_rise;
    logic sck_fall;

    assign cnt_end  = (cnt == DIV_LAST);
    assign accept   = (state == IDLE) && python_spi_valid && python_spi_ready;
    assign sck_rise = (state == SHIFT) && !python_sck && cnt_end;
    assign sck_fall = (state == SHIFT) && python_sck && cnt_end;

    // Frame shift register: loaded on accept, advanced on every SCK fall so bit [24] is always the next MOSI bit.
    always_ff @(posedge clk) begin
        if (accept) begin
            frame_q <= {python_spi_addr, python_spi_we,
                        (python_spi_we ? python_spi_wdata : 16'h0000)};
        end else if (sck_fall) begin
            frame_q <= {frame_q[24:0], 1'b0};
        end
    end

`ifdef PYTHON_SPI_MASTER_READBACK_EN
    // Only the 16 data bits (bit_idx 15..0) are captured from MISO.
    always_ff @(posedge clk) begin
        if (sck_rise && (bit_idx < 5'd16)) begin
            rx_word <= {rx_word[14:0], python_miso};
        end
    end
`else
    logic miso_unused;
    assign miso_unused = python_miso;
    assign rx_word     = 16'h0000;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            cnt               <= 8'd0;
            bit_idx           <= 5'd0;
            is_read           <= 1'b0;
            python_ss_n       <= 1'b1;
            python_sck        <= 1'b0;
            python_mosi       <= 1'b0;
            python_spi_ready  <= 1'b0;
            python_spi_rvalid <= 1'b0;
            python_spi_rdata  <= 16'h0000;
        end else begin
            python_spi_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        python_spi_ready <= 1'b0;
                        python_ss_n      <= 1'b0;
                        python_sck       <= 1'b0;
                        python_mosi      <= python_spi_addr[8];
                        is_read          <= !python_spi_we;
                        cnt              <= 8'd0;
                        bit_idx          <= 5'd25;
                        state            <= SHIFT;
                    end else begin
                        python_spi_ready <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt_end) begin
                        cnt        <= 8'd0;
                        python_sck <= !python_sck;
                        if (python_sck) begin
                            if (bit_idx == 5'd0) begin
                                state <= HOLD;
                            end else begin
                                bit_idx     <= bit_idx - 5'd1;
                                python_mosi <= frame_q[24];
                            end
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (cnt_end) begin
                        cnt         <= 8'd0;
                        python_ss_n <= 1'b1;
                        python_mosi <= 1'b0;
                        state       <= GAP;
                        if (is_read) begin
                            python_spi_rvalid <= 1'b1;
                            python_spi_rdata  <= rx_word;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_end) begin
                        cnt              <= 8'd0;
                        python_spi_ready <= 1'b1;
                        state            <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_python_spi_master.sv
// Bench for python_spi_master: CLK_DIV=4 and CLK_DIV=1 instances checked against a timing/frame model.
module tb_python_spi_master;

    logic        clk;
    logic        reset;
    logic [8:0]  addr;
    logic        we;
    logic [15:0] wdata;
    logic        valid_drv;
    logic        miso;
    int          sel;

    logic        valid4, ready4, rvalid4, ss4, sck4, mosi4;
    logic [15:0] rdata4;
    logic        valid1, ready1, rvalid1, ss1, sck1, mosi1;
    logic [15:0] rdata1;

    logic        o_ready, o_rvalid, o_ss_n, o_sck, o_mosi;
    logic [15:0] o_rdata;

    int          checks;
    int          errors;
    logic [15:0] exp_rd [2];

    assign valid4 = valid_drv && (sel == 0);
    assign valid1 = valid_drv && (sel == 1);

    assign o_ready  = (sel == 1) ? ready1  : ready4;
    assign o_rvalid = (sel == 1) ? rvalid1 : rvalid4;
    assign o_ss_n   = (sel == 1) ? ss1     : ss4;
    assign o_sck    = (sel == 1) ? sck1    : sck4;
    assign o_mosi   = (sel == 1) ? mosi1   : mosi4;
    assign o_rdata  = (sel == 1) ? rdata1  : rdata4;

    python_spi_master #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset),
        .python_spi_addr(addr), .python_spi_we(we), .python_spi_wdata(wdata),
        .python_spi_valid(valid4), .python_spi_ready(ready4),
        .python_spi_rdata(rdata4), .python_spi_rvalid(rvalid4),
        .python_ss_n(ss4), .python_sck(sck4), .python_mosi(mosi4), .python_miso(miso)
    );

    python_spi_master #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset),
        .python_spi_addr(addr), .python_spi_we(we), .python_spi_wdata(wdata),
        .python_spi_valid(valid1), .python_spi_ready(ready1),
        .python_spi_rdata(rdata1), .python_spi_rvalid(rvalid1),
        .python_ss_n(ss1), .python_sck(sck1), .python_mosi(mosi1), .python_miso(miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] readback(input logic [15:0] mw);
`ifdef PYTHON_SPI_MASTER_READBACK_EN
        return mw;
`else
        return 16'h0000;
`endif
    endfunction

    // One transaction: wait for ready, accept, then check every cycle 1..54*D+1 against the frame timing rules.
    task automatic run_frame(input int sel_i, input logic [8:0] a, input logic w,
                             input logic [15:0] wd, input logic [15:0] mw,
                             input bit keep, input bit immediate);
        int          d;
        int          guard;
        int          k;
        int          ph;
        logic [25:0] frame;
        logic [25:0] cap;
        logic        e_sck;
        logic        e_ss;
        d     = (sel_i == 1) ? 1 : 4;
        frame = {a, w, (w ? wd : 16'h0000)};
        sel   = sel_i;
        addr  = a;
        we    = w;
        wdata = wd;
        valid_drv = 1'b1;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", 32'(guard < 1000), 32'd1);
        if (immediate) chk("b2b_accept_cycle", 32'(guard), 32'd0);
        @(posedge clk);
        cap = '0;
        for (int n = 1; n <= 54 * d + 1; n++) begin
            @(negedge clk);
            if (n == 1) begin
                addr  = 9'($urandom);
                wdata = 16'($urandom);
                we    = 1'($urandom);
                if (!keep) valid_drv = 1'b0;
            end
            k  = (n - 1) / (2 * d);
            ph = (n - 1) % (2 * d);
            e_ss  = (n <= 53 * d) ? 1'b0 : 1'b1;
            e_sck = (n <= 52 * d) && (ph >= d);
            if (!w && n == 53 * d + 1) exp_rd[sel_i] = readback(mw);
            chk("ss_n", 32'(o_ss_n), 32'(e_ss));
            chk("sck", 32'(o_sck), 32'(e_sck));
            if (n <= 52 * d) chk("mosi_bit", 32'(o_mosi), 32'(frame[25 - k]));
            if (n > 53 * d) chk("mosi_idle", 32'(o_mosi), 32'd0);
            chk("ready", 32'(o_ready), 32'(n == 54 * d + 1));
            chk("rvalid", 32'(o_rvalid), 32'(!w && n == 53 * d + 1));
            chk("rdata", 32'(o_rdata), 32'(exp_rd[sel_i]));
            if (n <= 52 * d && ph == d) cap = {cap[24:0], o_mosi};
            miso = (k >= 10 && k <= 25) ? mw[25 - k] : 1'($urandom);
        end
        chk("mosi_frame", 32'(cap), 32'(frame));
    endtask

    initial begin
        logic [8:0]  ra;
        logic [15:0] rw;
        logic [15:0] rm;
        logic        rwe;
        bit          keep_prev;
        bit          keep_now;

        checks = 0;
        errors = 0;
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        reset = 1'b1;
        valid_drv = 1'b0;
        sel = 0;
        addr = '0;
        we = 1'b0;
        wdata = '0;
        miso = 1'b0;

        #3;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #0;
            chk("rst_ss_n", 32'(o_ss_n), 32'd1);
            chk("rst_sck", 32'(o_sck), 32'd0);
            chk("rst_mosi", 32'(o_mosi), 32'd0);
            chk("rst_ready", 32'(o_ready), 32'd0);
            chk("rst_rvalid", 32'(o_rvalid), 32'd0);
            chk("rst_rdata", 32'(o_rdata), 32'd0);
        end
        sel = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset4", 32'(ready4), 32'd1);
        chk("ready_after_reset1", 32'(ready1), 32'd1);

        // Directed write and read at CLK_DIV=4.
        run_frame(0, 9'h0A5, 1'b1, 16'h1234, 16'($urandom), 0, 0);
        run_frame(0, 9'h010, 1'b0, 16'hFFFF, 16'hBEEF, 0, 0);

        // valid held high across two writes.
        run_frame(0, 9'($urandom), 1'b1, 16'($urandom), 16'($urandom), 1, 0);
        run_frame(0, 9'($urandom), 1'b1, 16'($urandom), 16'($urandom), 0, 1);

        // Randomized mix, some back-to-back.
        keep_prev = 0;
        for (int i = 0; i < 6; i++) begin
            ra  = 9'($urandom);
            rw  = 16'($urandom);
            rm  = 16'($urandom);
            rwe = 1'($urandom);
            keep_now = (i < 5) ? 1'($urandom) : 1'b0;
            run_frame(0, ra, rwe, rw, rm, keep_now, keep_prev);
            keep_prev = keep_now;
        end

        // CLK_DIV=1 instance.
        run_frame(1, 9'($urandom), 1'b0, 16'($urandom), 16'h8001, 0, 0);
        for (int i = 0; i < 3; i++) begin
            run_frame(1, 9'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), 0, 0);
        end

        // Reset in the middle of a read at CLK_DIV=4.
        sel = 0;
        addr = 9'h033;
        we = 1'b0;
        valid_drv = 1'b1;
        while (o_ready !== 1'b1) @(negedge clk);
        @(posedge clk);
        for (int n = 1; n < 50; n++) begin
            @(negedge clk);
            valid_drv = 1'b0;
            miso = 1'($urandom);
        end
        @(negedge clk);
        chk("pre_abort_ss_n", 32'(o_ss_n), 32'd0);
        reset = 1'b1;
        #1;
        exp_rd[0] = 16'h0000;
        exp_rd[1] = 16'h0000;
        chk("abort_ss_n", 32'(o_ss_n), 32'd1);
        chk("abort_sck", 32'(o_sck), 32'd0);
        chk("abort_mosi", 32'(o_mosi), 32'd0);
        chk("abort_ready", 32'(o_ready), 32'd0);
        chk("abort_rvalid", 32'(o_rvalid), 32'd0);
        chk("abort_rdata", 32'(o_rdata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            chk("post_abort_ss_n", 32'(o_ss_n), 32'd1);
            chk("post_abort_rvalid", 32'(o_rvalid), 32'd0);
            chk("post_abort_ready", 32'(o_ready), 32'd1);
        end
        run_frame(0, 9'h1C3, 1'b1, 16'hA55A, 16'($urandom), 0, 0);
        run_frame(0, 9'h0F0, 1'b0, 16'($urandom), 16'($urandom), 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
